uart_autobaud: RTL

UART_AUTOBAUD -- requirements
Module: uart_autobaud

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx.sv | 107 ++++++++++
 rtl/uart_autobaud.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the autobaud UART
package uart_pkg;

  localparam int DIVW_DEF   = 16;
  localparam int MINBIT_DEF = 8;

  typedef enum logic [2:0] {
    RX_HUNT,
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Bit positions inside the status byte
  localparam int ST_LOCKED = 7;
  localparam int ST_FERR   = 6;
  localparam int ST_TXOVR  = 5;
  localparam int ST_TXBUSY = 4;
  localparam int ST_RXBUSY = 3;

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - transmitter with one holding register, timed by the measured divisor
module uart_tx
  import uart_pkg::*;
#(
  parameter int DIVW = DIVW_DEF
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [DIVW-1:0] divisor,
  input  logic            locked,
  input  logic            ovr_clr,
  input  logic [7:0]      od,
  input  logic            dox,
  output logic            txd,
  output logic            tx_busy,
  output logic            tx_ovr
);

  logic [9:0]      sh_q, sh_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            busy_q, busy_d;
  logic            ovr_q, ovr_d;
  logic [3:0]      bitn_q, bitn_d;
  logic [DIVW-1:0] tmr_q, tmr_d;
  logic [DIVW-1:0] reload;

  assign reload = divisor - DIVW'(1);

  always_comb begin
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    busy_d      = busy_q;
    ovr_d       = ovr_q;
    bitn_d      = bitn_q;
    tmr_d       = tmr_q;
    if (busy_q) begin
      if (tmr_q == '0) begin
        tmr_d = reload;
        if (bitn_q == 4'd9) begin
          // End of stop bit: chain the held byte with no idle gap
          bitn_d = '0;
          if (hold_full_q) begin
            sh_d        = {1'b1, hold_q, 1'b0};
            hold_full_d = 1'b0;
          end else begin
            sh_d   = '1;
            busy_d = 1'b0;
          end
        end else begin
          sh_d   = {1'b1, sh_q[9:1]};
          bitn_d = bitn_q + 4'd1;
        end
      end else begin
        tmr_d = tmr_q - DIVW'(1);
      end
    end
    if (ovr_clr) ovr_d = 1'b0;
    // Losing lock invalidates the divisor, so abandon any frame in flight
    if (!locked) begin
      sh_d        = '1;
      busy_d      = 1'b0;
      hold_full_d = 1'b0;
    end
    if (dox) begin
      if (!locked) begin
        ovr_d = 1'b1;
      end else if (!busy_d) begin
        sh_d   = {1'b1, od, 1'b0};
        busy_d = 1'b1;
        bitn_d = '0;
        tmr_d  = reload;
      end else if (!hold_full_d) begin
        hold_d      = od;
        hold_full_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sh_q        <= '1;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
      bitn_q      <= '0;
      tmr_q       <= '0;
    end else begin
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
      bitn_q      <= bitn_d;
      tmr_q       <= tmr_d;
    end
  end

  assign txd     = sh_q[0];
  assign tx_busy = busy_q;
  assign tx_ovr  = ovr_q;

endmodule

// File: rtl/uart_autobaud.sv
// rtl/uart_autobaud.sv - UART that measures its bit period from the first start bit
module uart_autobaud
  import uart_pkg::*;
#(
  parameter int DIVW   = DIVW_DEF,
  parameter int MINBIT = MINBIT_DEF
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            rxd,
  output logic            txd,
  output logic [7:0]      id,
  output logic            dix,
  input  logic [7:0]      od,
  input  logic            dox,
  output logic [7:0]      status,
  output logic [DIVW-1:0] divisor
);

  logic [1:0]      sync_q, sync_d;
  logic            rx_prev_q, rx_prev_d;
  rx_state_e       state_q, state_d;
  logic            meas_q, meas_d;
  logic [DIVW-1:0] tmr_q, tmr_d;
  logic [2:0]      bitn_q, bitn_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      id_q, id_d;
  logic            dix_q, dix_d;
  logic            ferr_q, ferr_d;
  logic            locked_q, locked_d;
  logic [DIVW-1:0] div_q, div_d;
  logic            lock_set;
  logic            rx, fall, rise, tick;
  logic [DIVW-1:0] tmr_dec, reload;
  logic            tx_busy, tx_ovr, rx_busy;

  assign rx      = sync_q[1];
  assign fall    = rx_prev_q & ~rx;
  assign rise    = ~rx_prev_q & rx;
  assign tick    = (tmr_q == '0);
  assign tmr_dec = tmr_q - DIVW'(1);
  assign reload  = div_q - DIVW'(1);

  always_comb begin
    sync_d    = {sync_q[0], rxd};
    rx_prev_d = rx;
    state_d   = state_q;
    meas_d    = meas_q;
    tmr_d     = tmr_q;
    bitn_d    = bitn_q;
    shreg_d   = shreg_q;
    id_d      = id_q;
    dix_d     = 1'b0;
    ferr_d    = ferr_q;
    locked_d  = locked_q;
    div_d     = div_q;
    lock_set  = 1'b0;
    case (state_q)
      RX_HUNT: begin
        if (!meas_q) begin
          if (fall) begin
            meas_d = 1'b1;
            tmr_d  = DIVW'(1);
          end
        end else if (rise) begin
          // The first low pulse is exactly the start bit; the line now sits at the start of bit0
          meas_d = 1'b0;
          if (tmr_q >= DIVW'(MINBIT) && tmr_q != '1) begin
            lock_set = 1'b1;
            locked_d = 1'b1;
            ferr_d   = 1'b0;
            div_d    = tmr_q;
            bitn_d   = '0;
            tmr_d    = (tmr_q >> 1) - DIVW'(1);
            state_d  = RX_DATA;
          end
        end else if (tmr_q != '1) begin
          tmr_d = tmr_q + DIVW'(1);
        end
      end
      RX_IDLE: begin
        if (fall) begin
          tmr_d   = (div_q >> 1) - DIVW'(1);
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (!tick) begin
          tmr_d = tmr_dec;
        end else if (!rx) begin
          tmr_d   = reload;
          bitn_d  = '0;
          state_d = RX_DATA;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (!tick) begin
          tmr_d = tmr_dec;
        end else begin
          shreg_d = {rx, shreg_q[7:1]};
          tmr_d   = reload;
          bitn_d  = bitn_q + 3'd1;
          if (bitn_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (!tick) begin
          tmr_d = tmr_dec;
        end else if (rx) begin
          id_d    = shreg_q;
          dix_d   = 1'b1;
          state_d = RX_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = RX_IDLE;
          // An all-zero frame with a low stop bit is a break: drop lock and re-measure
          if (shreg_q == 8'h00) begin
            locked_d = 1'b0;
            div_d    = '0;
            state_d  = RX_HUNT;
          end
        end
      end
      default: state_d = RX_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= RX_HUNT;
      meas_q    <= 1'b0;
      tmr_q     <= '0;
      bitn_q    <= '0;
      shreg_q   <= '0;
      id_q      <= '0;
      dix_q     <= 1'b0;
      ferr_q    <= 1'b0;
      locked_q  <= 1'b0;
      div_q     <= '0;
    end else begin
      sync_q    <= sync_d;
      rx_prev_q <= rx_prev_d;
      state_q   <= state_d;
      meas_q    <= meas_d;
      tmr_q     <= tmr_d;
      bitn_q    <= bitn_d;
      shreg_q   <= shreg_d;
      id_q      <= id_d;
      dix_q     <= dix_d;
      ferr_q    <= ferr_d;
      locked_q  <= locked_d;
      div_q     <= div_d;
    end
  end

  uart_tx #(.DIVW(DIVW)) u_tx (
    .clk     (clk),
    .nreset  (nreset),
    .divisor (div_q),
    .locked  (locked_q),
    .ovr_clr (lock_set),
    .od      (od),
    .dox     (dox),
    .txd     (txd),
    .tx_busy (tx_busy),
    .tx_ovr  (tx_ovr)
  );

  assign rx_busy = (state_q == RX_START) || (state_q == RX_DATA) || (state_q == RX_STOP) ||
                   ((state_q == RX_HUNT) && meas_q);

  always_comb begin
    status            = '0;
    status[ST_LOCKED] = locked_q;
    status[ST_FERR]   = ferr_q;
    status[ST_TXOVR]  = tx_ovr;
    status[ST_TXBUSY] = tx_busy;
    status[ST_RXBUSY] = rx_busy;
  end

  assign id      = id_q;
  assign dix     = dix_q;
  assign divisor = div_q;

endmodule
